// File: rtl/dice_pkg.sv
// dice_pkg: die codes, side-count lookup and tally FSM states shared by the roller and the tally
package dice_pkg;
  typedef enum logic [2:0] {D4 = 3'd1, D6, D8, D10, D12, D20} die_t;
  typedef enum logic [1:0] {S_IDLE, S_GAP, S_DONE} state_t;
  localparam logic [4:0] CLEAR = 5'd1;
  function automatic logic [4:0] die_sides(input logic [2:0] code);
    return code == D4  ? 5'd4  :
           code == D6  ? 5'd6  :
           code == D8  ? 5'd8  :
           code == D10 ? 5'd10 :
           code == D12 ? 5'd12 :
           code == D20 ? 5'd20 : 5'd0;
  endfunction
endpackage

// File: rtl/dice_range_check.sv
// dice_range_check: flags a roll value that lies within 1..sides of the given die
module dice_range_check
  import dice_pkg::*;
(
  input  logic [2:0] die,
  input  logic [4:0] value,
  output logic       valid
);
  assign valid = value != 5'd0 && value <= die_sides(die);
endmodule

// File: rtl/dice_tally.sv
// dice_tally: samples the roller every GAP cycles and accumulates sum/max/min/count of valid rolls
module dice_tally
  import dice_pkg::*;
#(
  parameter int MAX_DICE  = 8,
  parameter int GAP       = 3,
  parameter int RETRY_MAX = 4,
  parameter int SUM_W     = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             start,
  input  logic [2:0]       die,
  input  logic [3:0]       num_dice,
  input  logic [4:0]       roll_result,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [SUM_W-1:0] sum,
  output logic [4:0]       max_val,
  output logic [4:0]       min_val,
  output logic [3:0]       count
);
  localparam int GW = GAP > 1 ? $clog2(GAP) : 1;
  localparam int RW = $clog2(RETRY_MAX + 1);
  state_t        state, state_n;
  logic [2:0]    die_q;
  logic [3:0]    target;
  logic [GW-1:0] gap_cnt;
  logic [RW-1:0] retry_cnt;
  logic [4:0]    min_int;
  logic          valid, accept, bad_die, sample, finish;
  dice_range_check u_check (.die(die_q), .value(roll_result), .valid(valid));
  assign accept  = state == S_IDLE && start && num_dice != 4'd0;
  assign bad_die = die_sides(die) == 5'd0;
  assign sample  = state == S_GAP && gap_cnt == '0;
  assign finish  = valid ? count + 4'd1 == target : retry_cnt == RW'(RETRY_MAX - 1);
  assign busy    = state == S_GAP;
  assign done    = state == S_DONE;
  assign min_val = count == 4'd0 ? 5'd0 : min_int;
  // state register
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= S_IDLE;
    else state <= state_n;
  // next state: clear wins, bad die skips straight to DONE, finish on target or retry exhaustion
  always_comb begin
    state_n = state;
    state_n = clear ? S_IDLE :
              state == S_IDLE ? (accept ? (bad_die ? S_DONE : S_GAP) : S_IDLE) :
              state == S_GAP  ? (sample && finish ? S_DONE : S_GAP) : S_IDLE;
  end
  // request latch, gap/retry counters and result accumulators
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      die_q     <= '0;
      target    <= '0;
      gap_cnt   <= '0;
      retry_cnt <= '0;
      sum       <= '0;
      max_val   <= '0;
      min_int   <= 5'd31;
      count     <= '0;
      err       <= 1'b0;
    end else if (clear) begin
      gap_cnt   <= '0;
      retry_cnt <= '0;
      sum       <= '0;
      max_val   <= '0;
      min_int   <= 5'd31;
      count     <= '0;
      err       <= 1'b0;
    end else if (accept) begin
      die_q     <= die;
      target    <= num_dice > 4'(MAX_DICE) ? 4'(MAX_DICE) : num_dice;
      gap_cnt   <= GW'(GAP - 1);
      retry_cnt <= '0;
      sum       <= '0;
      max_val   <= '0;
      min_int   <= 5'd31;
      count     <= '0;
      err       <= bad_die;
    end else if (state == S_GAP) begin
      gap_cnt <= sample ? GW'(GAP - 1) : gap_cnt - 1'b1;
      if (sample && valid) begin
        sum       <= sum + SUM_W'(roll_result);
        count     <= count + 4'd1;
        max_val   <= roll_result > max_val ? roll_result : max_val;
        min_int   <= roll_result < min_int ? roll_result : min_int;
        retry_cnt <= '0;
      end else if (sample) begin
        err       <= 1'b1;
        retry_cnt <= retry_cnt + 1'b1;
      end
    end
endmodule

// File: doc/dice_tally.md
# dice_tally

Downstream consumer of the dice roller's free-running `roll_result`. On a start request, the block samples the roller output once every `GAP` cycles until it has collected `num_dice` valid rolls. It accumulates the sum, maximum, minimum and count of those rolls and presents them with a one-cycle `done` strobe. It sits between the roller and the display/score logic.

## Interface
- `MAX_DICE`, 8: largest number of dice per request.
- `GAP`, 3: cycles between samples, ≥1.
- `RETRY_MAX`, 4: consecutive invalid samples tolerated before abort.
- `SUM_W`, 9: sum width; must hold 20·`MAX_DICE`.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; all state and outputs cleared.
- `clear` in 1: synchronous; returns to IDLE and zeroes results.
- `start` in 1: request a tally; honoured only in IDLE.
- `die` in 3: die code (001=d4, 010=d6, 011=d8, 100=d10, 101=d12, 110=d20); latched at start.
- `num_dice` in 4: dice to roll; latched at start.
- `roll_result` in 5: roller output, 1..20.
- `busy` out 1: high from the cycle after an accepted start until `done`.
- `done` out 1: one-cycle strobe when results are final.
- `err` out 1: sticky until the next accepted start or `clear`.
- `sum` out `SUM_W`: sum of valid samples.
- `max_val` out 5: largest valid sample.
- `min_val` out 5: smallest valid sample.
- `count` out 4: number of valid samples.

## Operation
- States: IDLE, GAP, DONE.
- Reset values: state IDLE; all outputs 0.
- **IDLE**
  - `start` with `num_dice`=0 is ignored.
  - `num_dice` > `MAX_DICE` is clamped to `MAX_DICE`.
  - `start` with an invalid die code (000, 111) goes to DONE with `err`=1 and `count`=0.
  - Otherwise: latch `die` and target; set `sum`=0, `count`=0, `max_val`=0, internal min=31, `err`=0, gap counter=`GAP`-1; go to GAP.
- **GAP**
  - Counter decrements each cycle.
  - At the edge where the counter is 0, sample `roll_result`.
  - Valid sample (1 ≤ v ≤ sides of latched die):
    - `sum`+=v, `count`+=1, update `max_val`/`min_val`, reset retry count.
    - If `count` reaches target, go to DONE; else reload counter with `GAP`-1.
  - Invalid sample:
    - Not accumulated; `err`=1; retry count +1; reload counter.
    - When the retry count reaches `RETRY_MAX`, go to DONE with partial results.
- **DONE**: `done`=1 for exactly one cycle, then IDLE.
- Results hold until the next accepted start, `clear` or `reset`.
- `min_val` reads 0 whenever `count`=0.
- Width rules:
  - `sum` never wraps for legal parameters.
  - The die-sides lookup is compared as 5-bit unsigned.
- `start` while busy or in DONE is ignored; there is no queueing.
- `clear` takes priority over `start` and over sampling in the same cycle.

## Timing
- Start accepted at edge k:
  - `busy`=1 after edge k.
  - Sample i (i=1..N) is taken at edge k+i·`GAP`, assuming no retries.
  - After edge k+N·`GAP`: `done`=1, `busy`=0; outputs already final.
  - `done` drops after edge k+N·`GAP`+1.
- Each invalid sample adds `GAP` cycles.
- `busy` and `done` are never high together.
- Invalid-die start: `done` is high in the cycle after edge k.
- Async `reset` mid-tally: outputs 0 immediately; no `done`.
- `clear` mid-tally: IDLE after the next edge; no `done`.
- Inputs are sampled only at rising edges; `roll_result` is needed only at sample edges.

## Structure
- Package `dice_pkg`:
  - die-code enum (`D4`..`D20`);
  - `die_sides(code)` function returning 5-bit max, or 0 for invalid codes;
  - `CLEAR`=5'd1;
  - the state enum.
- The dice roller shares the package's die codes.
- Sub-module `dice_range_check`: combinational; takes `die` and value, returns valid. Instantiated once.
- Remainder (FSM, gap/retry counters, accumulators) lives in `dice_tally`.

## Test plan
- d20, N=3, `GAP`=3, roll_result driven 5, 17, 20 at the sample edges → `sum`=42, `max_val`=20, `min_val`=5, `count`=3, `err`=0; `done` one cycle at k+9.
- d4, N=2, samples 3, 9, 2 → 9 rejected; `sum`=5, `count`=2, `err`=1; `done` at k+9.
- d6, N=4, roll_result stuck at 0 → abort after 4 invalid samples; `count`=0, `min_val`=0, `err`=1, `done` at k+12.
- `num_dice`=15 with d20, all samples 20 → clamped to 8; `sum`=160, `count`=8.
- `start` with `die`=3'b111 → `done` next cycle, `err`=1; `start` with `num_dice`=0 → `busy` stays 0.
- Async `reset` at k+4 of a d8 N=3 tally → all outputs 0 at once, no `done`; a repeated `start` while busy has no effect on latched die/target.
